// File: rtl/prog_clk_divider.sv
// NUM_CH-channel programmable clock divider. Each channel divides clk by a runtime divisor
// (even or odd). Divisor changes are double-buffered and take effect only at a period boundary.
module prog_clk_divider #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              restart,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_err_clr,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] period_start,
    output logic              cfg_err
);

    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [DIV_W-1:0]  act_q [NUM_CH];
    logic [DIV_W-1:0]  act_d [NUM_CH];
    logic [DIV_W-1:0]  shd_q [NUM_CH];
    logic [DIV_W-1:0]  shd_d [NUM_CH];
    logic [NUM_CH-1:0] div_q, div_d;
    logic [NUM_CH-1:0] ps_q, ps_d;
    logic              err_q, err_d;

    logic              cfg_ok;
    logic              cfg_bad;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] start;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cfg_ok  = cfg_wr && (cfg_div >= DIV_W'(2)) && (int'(cfg_ch) < NUM_CH);
        cfg_bad = cfg_wr && !cfg_ok;
        hit     = '0;
        start   = '0;
        div_d   = '0;
        ps_d    = '0;
        err_d   = err_q;

        if (cfg_bad) begin
            err_d = 1'b1;
        end else if (cfg_err_clr) begin
            err_d = 1'b0;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            hit[c]   = cfg_ok && (int'(cfg_ch) == c);
            shd_d[c] = hit[c] ? cfg_div : shd_q[c];
            act_d[c] = act_q[c];
            cnt_d[c] = cnt_q[c];

            // cnt==0 only while idle, so it doubles as the "was disabled" marker.
            start[c] = ch_en[c] && (restart || (cnt_q[c] == '0) || (cnt_q[c] == act_q[c]));

            if (!ch_en[c]) begin
                cnt_d[c] = '0;
            end else if (start[c]) begin
                // Shadow write-through: a write on a boundary edge is used for this very period.
                act_d[c] = shd_d[c];
                cnt_d[c] = DIV_W'(1);
                div_d[c] = 1'b1;
                ps_d[c]  = 1'b1;
            end else begin
                // Compare before increment so cnt never exceeds act, even at the maximum divisor.
                cnt_d[c] = cnt_q[c] + DIV_W'(1);
                div_d[c] = cnt_q[c] < ((act_q[c] >> 1) + {{(DIV_W-1){1'b0}}, act_q[c][0]});
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: divisor register arrays are reset on purpose: every channel must come up at DEFAULT_DIV.
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                act_q[c] <= DIV_W'(DEFAULT_DIV);
                shd_q[c] <= DIV_W'(DEFAULT_DIV);
            end
            div_q <= '0;
            ps_q  <= '0;
            err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
                act_q[c] <= act_d[c];
                shd_q[c] <= shd_d[c];
            end
            div_q <= div_d;
            ps_q  <= ps_d;
            err_q <= err_d;
        end
    end

    assign div_out      = div_q;
    assign period_start = ps_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed scenarios plus random traffic, compared every
// cycle against a period-position model of each channel.
module tb_prog_clk_divider;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int CH_W        = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NUM_CH-1:0] ch_en;
    logic              restart;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_err_clr;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] period_start;
    logic              cfg_err;

    prog_clk_divider #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ch_en        (ch_en),
        .restart      (restart),
        .cfg_wr       (cfg_wr),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_err_clr  (cfg_err_clr),
        .div_out      (div_out),
        .period_start (period_start),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: position within the current period (0-based cycle index) per channel.
    int                m_a   [NUM_CH];
    int                m_s   [NUM_CH];
    int                m_pos [NUM_CH];
    bit                m_run [NUM_CH];
    bit                m_err;
    logic [NUM_CH-1:0] exp_div;
    logic [NUM_CH-1:0] exp_ps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_a[c]   = DEFAULT_DIV;
            m_s[c]   = DEFAULT_DIV;
            m_pos[c] = 0;
            m_run[c] = 1'b0;
        end
        m_err   = 1'b0;
        exp_div = '0;
        exp_ps  = '0;
    endtask

    task automatic model_step();
        bit ok;
        ok = cfg_wr && (int'(cfg_div) >= 2) && (int'(cfg_ch) < NUM_CH);
        if (ok) m_s[int'(cfg_ch)] = int'(cfg_div);
        if (cfg_wr && !ok) m_err = 1'b1;
        else if (cfg_err_clr) m_err = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!ch_en[c]) begin
                m_run[c] = 1'b0;
            end else if (!m_run[c] || restart || (m_pos[c] == m_a[c] - 1)) begin
                m_a[c]   = m_s[c];
                m_pos[c] = 0;
                m_run[c] = 1'b1;
            end else begin
                m_pos[c]++;
            end
            exp_div[c] = m_run[c] && (m_pos[c] < (m_a[c] + 1) / 2);
            exp_ps[c]  = m_run[c] && (m_pos[c] == 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("div_out", 32'(div_out), 32'(exp_div));
        check("period_start", 32'(period_start), 32'(exp_ps));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic wr(input int ch, input int d);
        cfg_wr  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(d);
        tick();
        cfg_wr  = 1'b0;
    endtask

    task automatic wait_ps(input int c, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start[c] && n < 600);
        if (!period_start[c]) check("timeout_period_start", 32'(0), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, lo;
        resetn      = 1'b0;
        ch_en       = '0;
        restart     = 1'b0;
        cfg_wr      = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_err_clr = 1'b0;
        model_reset();

        #12;
        check("reset_div_out", 32'(div_out), 32'(0));
        check("reset_period_start", 32'(period_start), 32'(0));
        check("reset_cfg_err", 32'(cfg_err), 32'(0));
        @(posedge clk);
        #1 resetn = 1'b1;

        // Default D=2 on all channels.
        ch_en = '1;
        tick();
        check("d2_first_high", 32'(div_out), 32'(3'b111));
        repeat (7) tick();

        // ch1 D=3, ch2 D=6 from a clean start.
        ch_en = '0;
        tick();
        wr(1, 3);
        wr(2, 6);
        ch_en = '1;
        repeat (24) tick();

        // ch0 D=4; write D=5 on the edge where cnt=2 -> this period stays 4, later ones are 5.
        ch_en = '0;
        tick();
        wr(0, 4);
        ch_en = 3'b001;
        tick();
        n = 0;
        do begin
            if (n == 1) begin
                cfg_wr  = 1'b1;
                cfg_ch  = 2'd0;
                cfg_div = 8'd5;
            end
            tick();
            cfg_wr = 1'b0;
            n++;
        end while (!period_start[0] && n < 20);
        check("d4_period_len", 32'(n), 32'(4));
        wait_ps(0, n);
        check("d5_period_len", 32'(n), 32'(5));

        // Invalid writes: divisor 1, divisor 0, channel out of range.
        wr(0, 1);
        check("err_div1", 32'(cfg_err), 32'(1));
        wr(1, 0);
        wr(NUM_CH, 7);
        check("err_sticky", 32'(cfg_err), 32'(1));
        cfg_err_clr = 1'b1;
        wr(0, 0);
        check("err_set_wins", 32'(cfg_err), 32'(1));
        tick();
        cfg_err_clr = 1'b0;
        check("err_cleared", 32'(cfg_err), 32'(0));
        wait_ps(0, n);
        check("d5_kept", 32'(n), 32'(5));

        // Restart mid-period with ch1 disabled.
        wr(2, 7);
        ch_en = 3'b101;
        repeat (3) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_div_out", 32'(div_out), 32'(3'b101));
        check("restart_ps", 32'(period_start), 32'(3'b101));
        repeat (10) tick();

        // Async reset in the high phase of a D=255 period.
        ch_en = '0;
        tick();
        wr(0, 255);
        wr(0, 1);
        ch_en = 3'b001;
        repeat (50) tick();
        #2 resetn = 1'b0;
        #1;
        check("async_div_out", 32'(div_out), 32'(0));
        check("async_period_start", 32'(period_start), 32'(0));
        check("async_cfg_err", 32'(cfg_err), 32'(0));
        model_reset();
        ch_en = '0;
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        ch_en = 3'b001;
        wr(0, 255);
        check("d255_first_high", 32'(div_out[0]), 32'(1));
        hi = 1;
        while (hi < 300) begin
            tick();
            if (div_out[0]) hi++;
            else break;
        end
        lo = 1;
        while (lo < 300) begin
            tick();
            if (!div_out[0]) lo++;
            else break;
        end
        check("d255_high_len", 32'(hi), 32'(128));
        check("d255_low_len", 32'(lo), 32'(127));

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            int r;
            if ($urandom_range(0, 39) == 0) ch_en[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            restart     = ($urandom_range(0, 59) == 0);
            cfg_err_clr = ($urandom_range(0, 19) == 0);
            cfg_wr      = ($urandom_range(0, 14) == 0);
            cfg_ch      = CH_W'($urandom_range(0, 3));
            r = $urandom_range(0, 19);
            if (r == 0)      cfg_div = 8'd0;
            else if (r == 1) cfg_div = 8'd1;
            else if (r == 2) cfg_div = 8'd255;
            else             cfg_div = DIV_W'($urandom_range(2, 9));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
